// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with a registered, sync-aligned test-pattern source.
// Optional macro VGA_PATTERN_SCROLL_EN: bars and gradient scroll left one pixel per frame.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_ACTIVE / 8);
  localparam logic             HS_ON  = (HS_POL != 0);
  localparam logic             VS_ON  = (VS_POL != 0);
  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};

  logic [CNT_W-1:0]     h_q, h_d, v_q, v_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 seen_q, seen_d;
  logic [1:0]           mode_q, mode_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d;

  logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CNT_W-1:0]     x_q, x_d, y_q, y_d;
  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Counters, completed-frame count and frame-boundary latching of mode/colour
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    seen_d      = seen_q;
    mode_d      = mode_q;
    solid_d     = solid_q;
    if (enable) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      if ((h_q == H_MAX) && (v_q == V_MAX)) begin
        mode_d  = mode;
        solid_d = solid_rgb;
      end
      if ((h_q == '0) && (v_q == '0)) begin
        seen_d = 1'b1;
        if (seen_q) frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  logic [CNT_W-1:0] px;
`ifdef VGA_PATTERN_SCROLL_EN
  localparam logic [CNT_W:0] H_ACT_W = (CNT_W+1)'(H_ACTIVE);
  logic [CNT_W:0] scroll_sum;
  // frame_cnt_d is the count shown alongside this pixel
  assign scroll_sum = {1'b0, h_q} + {1'b0, frame_cnt_d[CNT_W-1:0]};
  assign px         = CNT_W'(scroll_sum % H_ACT_W);
`else
  assign px = h_q;
`endif

  logic [CNT_W-1:0]   bar_q;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] diag;
  logic               grid_on;

  assign bar_q   = px / BAR_W;
  assign bar_idx = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
  assign diag    = px[COLOR_W-1:0] + v_q[COLOR_W-1:0];
  assign grid_on = (h_q[3:0] == 4'd0) || (v_q[3:0] == 4'd0) ||
                   (h_q == H_LAST) || (v_q == V_LAST);

  always_comb begin
    de_d          = enable && (h_q < H_ACT) && (v_q < V_ACT);
    hsync_d       = (enable && (h_q >= HS_BEG) && (h_q < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d       = (enable && (v_q >= VS_BEG) && (v_q < VS_END)) ? VS_ON : ~VS_ON;
    line_start_d  = enable && (h_q == '0);
    frame_start_d = enable && (h_q == '0) && (v_q == '0);
    x_d           = h_q;
    y_d           = v_q;
    r_d           = '0;
    g_d           = '0;
    b_d           = '0;
    if (de_d) begin
      unique case (mode_q)
        2'd0: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          r_d = bar_idx[1] ? '0 : FULL;
          g_d = bar_idx[2] ? '0 : FULL;
          b_d = bar_idx[0] ? '0 : FULL;
        end
        2'd1: begin
          r_d = grid_on ? FULL : '0;
          g_d = grid_on ? FULL : '0;
          b_d = grid_on ? FULL : '0;
        end
        2'd2: begin
          r_d = px[COLOR_W-1:0];
          g_d = v_q[COLOR_W-1:0];
          b_d = diag;
        end
        default: {r_d, g_d, b_d} = solid_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_cnt_q   <= '0;
      seen_q        <= 1'b0;
      mode_q        <= '0;
      solid_q       <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_cnt_q   <= frame_cnt_d;
      seen_q        <= seen_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Directed bench: default 640x480 instance for line timing and bars, tiny instance for frame behaviour.
module tb_vga_timing_pattern_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default-parameter instance
  logic        enable_a;
  logic [1:0]  mode_a;
  logic [23:0] solid_a;
  logic        hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [11:0] x_a, y_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [15:0] fc_a;

  vga_timing_pattern_gen u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .mode(mode_a), .solid_rgb(solid_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .r(r_a), .g(g_a), .b(b_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  // Tiny instance: line 12 clocks, frame 84 clocks, hsync active-high at h = 9..10
  logic        enable_b;
  logic [1:0]  mode_b;
  logic [23:0] solid_b;
  logic        hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [7:0]  x_b, y_b;
  logic [7:0]  r_b, g_b, b_b;
  logic [15:0] fc_b;

  vga_timing_pattern_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .COLOR_W(8), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .mode(mode_b), .solid_rgb(solid_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .r(r_b), .g(g_b), .b(b_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  task automatic wait_fs_b(input int bound);
    int   n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < bound) begin
      tick();
      n++;
      if (fs_b) found = 1'b1;
    end
    check_val("b_fs_timeout", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_fall, hs_low, ls_at;
    int ls_n, vs_low, vs_first, hs_hi, de_n;

    rst_n = 1'b0;
    enable_a = 1'b0; mode_a = 2'd0; solid_a = 24'h0;
    enable_b = 1'b0; mode_b = 2'd0; solid_b = 24'h0;
    #22;
    check_val("a_rst_hsync", hsync_a, 1);
    check_val("a_rst_vsync", vsync_a, 1);
    check_val("a_rst_de", de_a, 0);
    check_val("a_rst_rgb", {r_a, g_a, b_a}, 24'h0);
    check_val("a_rst_fc", fc_a, 0);
    check_val("a_rst_ls", ls_a, 0);
    check_val("b_rst_hsync", hsync_b, 0);

    // ---- default instance: first line ----
    rst_n = 1'b1;
    enable_a = 1'b1;
    tick();
    check_val("a_first_ls", ls_a, 1);
    check_val("a_first_fs", fs_a, 1);
    check_val("a_first_x", x_a, 0);
    check_val("a_first_de", de_a, 1);
    check_val("a_first_rgb", {r_a, g_a, b_a}, 24'hFFFFFF);
    check_val("a_first_fc", fc_a, 0);
    hs_fall = -1; hs_low = 0; ls_at = -1;
    for (int n = 1; n <= 800; n++) begin
      tick();
      if (n == 79)  check_val("a_x79_rgb", {r_a, g_a, b_a}, 24'hFFFFFF);
      if (n == 80)  check_val("a_x80_rgb", {r_a, g_a, b_a}, 24'hFFFF00);
      if (n == 639) begin
        check_val("a_x639_rgb", {r_a, g_a, b_a}, 24'h000000);
        check_val("a_x639_de", de_a, 1);
      end
      if (n == 640) check_val("a_x640_de", de_a, 0);
      if (!hsync_a) begin
        hs_low++;
        if (hs_fall < 0) hs_fall = n;
      end
      if (ls_a && ls_at < 0) begin
        ls_at = n;
        check_val("a_line1_y", y_a, 1);
      end
    end
    check_val("a_hs_start", hs_fall, 656);
    check_val("a_hs_width", hs_low, 96);
    check_val("a_line_period", ls_at, 800);
    enable_a = 1'b0;

    // ---- tiny instance: one full frame with a mid-frame mode change ----
    rst_n = 1'b0;
    #2;
    check_val("b_rst_vsync", vsync_b, 1);
    check_val("b_rst_x", x_b, 0);
    rst_n = 1'b1;
    enable_b = 1'b1;
    solid_b = 24'h123456;
    tick();
    check_val("b_first_fs", fs_b, 1);
    check_val("b_first_fc", fc_b, 0);
    check_val("b_first_rgb", {r_b, g_b, b_b}, 24'hFFFFFF);
    check_val("b_first_hsync", hsync_b, 0);
    ls_n = 0; vs_low = 0; vs_first = -1; hs_hi = 0; de_n = 0;
    for (int i = 1; i <= 84; i++) begin
      tick();
      if (i < 12) begin
        check_val("b_line_x", x_b, i);
        check_val("b_line_de", de_b, (i < 8) ? 1 : 0);
        check_val("b_line_hsync", hsync_b, (i == 9 || i == 10) ? 1 : 0);
      end
      if (i == 3) check_val("b_bar3_rgb", {r_b, g_b, b_b}, 24'h00FF00);
      if (i == 7) check_val("b_bar7_rgb", {r_b, g_b, b_b}, 24'h000000);
      if (i == 20) mode_b = 2'd3;
      if (i == 36) begin
        check_val("b_y3_y", y_b, 3);
        check_val("b_no_tear_rgb", {r_b, g_b, b_b}, 24'hFFFFFF);
      end
      if (ls_b) ls_n++;
      if (!vsync_b) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
      if (hsync_b) hs_hi++;
      if (de_b) de_n++;
    end
    check_val("b_frame_fs", fs_b, 1);
    check_val("b_frame_xy", {x_b, y_b}, 16'h0000);
    check_val("b_solid_rgb", {r_b, g_b, b_b}, 24'h123456);
    check_val("b_frame_fc", fc_b, 1);
    check_val("b_lines", ls_n, 7);
    check_val("b_vs_width", vs_low, 12);
    check_val("b_vs_start", vs_first, 60);
    check_val("b_hs_count", hs_hi, 14);
    check_val("b_de_count", de_n, 32);

    // ---- freeze with enable low at (6,2) ----
    mode_b = 2'd2;
    for (int i = 0; i < 29; i++) tick();
    check_val("b_pre_freeze_xy", {x_b, y_b}, 16'h0502);
    check_val("b_pre_freeze_rgb", {r_b, g_b, b_b}, 24'h123456);
    enable_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("b_frz_de", de_b, 0);
      check_val("b_frz_rgb", {r_b, g_b, b_b}, 24'h0);
      check_val("b_frz_sync", {hsync_b, vsync_b}, 2'b01);
      check_val("b_frz_ls", ls_b, 0);
    end
    check_val("b_frz_fc", fc_b, 1);
    enable_b = 1'b1;
    tick();
    check_val("b_resume_xy", {x_b, y_b}, 16'h0602);
    check_val("b_resume_de", de_b, 1);
    check_val("b_resume_rgb", {r_b, g_b, b_b}, 24'h123456);

    // ---- gradient frame ----
    wait_fs_b(200);
    check_val("b_grad_fc", fc_b, 2);
    check_val("b_grad0_rgb", {r_b, g_b, b_b}, 24'h000000);
    for (int i = 0; i < 41; i++) tick();
    check_val("b_grad_xy", {x_b, y_b}, 16'h0503);
    check_val("b_grad_rgb", {r_b, g_b, b_b}, 24'h050308);

    // ---- asynchronous reset mid-frame ----
    #2;
    rst_n = 1'b0;
    #1;
    check_val("b_arst_xy", {x_b, y_b}, 16'h0000);
    check_val("b_arst_de", de_b, 0);
    check_val("b_arst_rgb", {r_b, g_b, b_b}, 24'h0);
    check_val("b_arst_fc", fc_b, 0);
    check_val("b_arst_sync", {hsync_b, vsync_b}, 2'b01);
    check_val("b_arst_pulses", {ls_b, fs_b}, 2'b00);
    rst_n = 1'b1;
    tick();
    check_val("b_post_fs", fs_b, 1);
    check_val("b_post_bars", {r_b, g_b, b_b}, 24'hFFFFFF);
    check_val("b_post_fc", fc_b, 0);
    wait_fs_b(200);
    check_val("b_relatch_fc", fc_b, 1);
    check_val("b_relatch0_rgb", {r_b, g_b, b_b}, 24'h000000);
    tick();
    check_val("b_relatch1_rgb", {r_b, g_b, b_b}, 24'h010001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
